// File: rtl/fifo_loc_tracker.sv
`default_nettype none
// ============================================================================
// Module      : fifo_loc_tracker
// Description : Single-clock FIFO occupancy tracker. Holds the write and read
//               pointers, issues the memory write/read strobes and addresses,
//               and keeps a registered count of free locations for the
//               downstream full/empty compare stage.
// Ports       : CLK          clock, rising edge
//               RST          asynchronous reset, active-low
//               CLR          synchronous flush, active-high
//               WR_EN/RD_EN  write / read requests
//               mem_wr_en    accepted-write strobe, mem_wr_addr = write pointer
//               mem_rd_en    accepted-read strobe,  mem_rd_addr = read pointer
//               empty_loc    registered free-location count, 0..2**ADDR_WIDTH
//               OVERFLOW     sticky, write requested while full
//               UNDERFLOW    sticky, read requested while empty
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_loc_tracker #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  WR_EN,
  input  logic                  RD_EN,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [ADDR_WIDTH:0]   empty_loc,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam logic [ADDR_WIDTH:0]   c_SIZE     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   c_ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_ONE_PTR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_empty_loc;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Full/empty come only from the registered count, so requests never feed
  // the acceptance decision combinationally through the count.
  assign w_full  = (r_empty_loc == '0);
  assign w_empty = (r_empty_loc == c_SIZE);

  // Gating with RST keeps the strobes low during reset even though the
  // reset count (SIZE) alone would not block a write.
  assign w_wr_acc = WR_EN & ~w_full  & ~CLR & RST;
  assign w_rd_acc = RD_EN & ~w_empty & ~CLR & RST;

  assign mem_wr_en   = w_wr_acc;
  assign mem_wr_addr = r_wr_ptr;
  assign mem_rd_en   = w_rd_acc;
  assign mem_rd_addr = r_rd_ptr;
  assign empty_loc   = r_empty_loc;
  assign OVERFLOW    = r_overflow;
  assign UNDERFLOW   = r_underflow;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_empty_loc <= c_SIZE;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (CLR) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_empty_loc <= c_SIZE;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Pointers wrap naturally at ADDR_WIDTH bits.
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_ONE_PTR;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_ONE_PTR;

      // Acceptance already excludes writes when full and reads when empty,
      // so the count cannot leave 0..SIZE.
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_empty_loc <= r_empty_loc - c_ONE_CNT;
        2'b01:   r_empty_loc <= r_empty_loc + c_ONE_CNT;
        default: r_empty_loc <= r_empty_loc;
      endcase

      if (WR_EN & w_full)  r_overflow  <= 1'b1;
      if (RD_EN & w_empty) r_underflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_loc_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_loc_tracker
// Description : Directed self-checking bench for fifo_loc_tracker with
//               ADDR_WIDTH=4 (16 locations). Inputs change on the falling
//               edge; outputs are sampled 1 ns later, away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_loc_tracker;

  localparam int ADDR_WIDTH = 4;

  logic                  CLK;
  logic                  RST;
  logic                  CLR;
  logic                  WR_EN;
  logic                  RD_EN;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [ADDR_WIDTH:0]   empty_loc;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  int checks = 0;
  int errors = 0;

  fifo_loc_tracker #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CLR         (CLR),
    .WR_EN       (WR_EN),
    .RD_EN       (RD_EN),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .empty_loc   (empty_loc),
    .OVERFLOW    (OVERFLOW),
    .UNDERFLOW   (UNDERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: pass the rising edge and land on the next falling edge.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      WR_EN = 1'b1;
      next_cycle();
    end
    WR_EN = 1'b0;
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      RD_EN = 1'b1;
      next_cycle();
    end
    RD_EN = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b0; CLR = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0;
    next_cycle();
    next_cycle();
    RST = 1'b1;

    // 1. Reset / idle state
    #1;
    check("rst_empty_loc", 32'(empty_loc), 16);
    check("rst_wr_addr",   32'(mem_wr_addr), 0);
    check("rst_rd_addr",   32'(mem_rd_addr), 0);
    check("rst_wr_en",     32'(mem_wr_en), 0);
    check("rst_rd_en",     32'(mem_rd_en), 0);
    check("rst_ovf",       32'(OVERFLOW), 0);
    check("rst_udf",       32'(UNDERFLOW), 0);
    next_cycle();
    check("idle_empty_loc", 32'(empty_loc), 16);

    // 2. Fill with 16 writes, then one rejected write
    for (int i = 0; i < 16; i++) begin
      WR_EN = 1'b1;
      #1;
      check("fill_wr_en",   32'(mem_wr_en), 1);
      check("fill_wr_addr", 32'(mem_wr_addr), 32'(i));
      check("fill_cnt",     32'(empty_loc), 32'(16 - i));
      next_cycle();
    end
    #1;
    check("full_cnt",     32'(empty_loc), 0);
    check("full_wr_en",   32'(mem_wr_en), 0);
    check("full_wr_addr", 32'(mem_wr_addr), 0);
    check("full_ovf_pre", 32'(OVERFLOW), 0);
    next_cycle();
    WR_EN = 1'b0;
    #1;
    check("ovf_set",      32'(OVERFLOW), 1);
    check("ovf_cnt",      32'(empty_loc), 0);
    check("ovf_wr_addr",  32'(mem_wr_addr), 0);
    next_cycle();

    // 3. Drain with 16 reads, then one rejected read
    for (int i = 0; i < 16; i++) begin
      RD_EN = 1'b1;
      #1;
      check("drain_rd_en",   32'(mem_rd_en), 1);
      check("drain_rd_addr", 32'(mem_rd_addr), 32'(i));
      check("drain_cnt",     32'(empty_loc), 32'(i));
      next_cycle();
    end
    #1;
    check("empty_cnt",   32'(empty_loc), 16);
    check("empty_rd_en", 32'(mem_rd_en), 0);
    next_cycle();
    RD_EN = 1'b0;
    #1;
    check("udf_set",     32'(UNDERFLOW), 1);
    check("udf_cnt",     32'(empty_loc), 16);
    check("udf_rd_addr", 32'(mem_rd_addr), 0);
    check("ovf_held",    32'(OVERFLOW), 1);
    next_cycle();

    // 4. Simultaneous read/write: mid-level, full, empty
    write_n(8);
    for (int k = 0; k < 20; k++) begin
      WR_EN = 1'b1; RD_EN = 1'b1;
      #1;
      check("both_wr_en",   32'(mem_wr_en), 1);
      check("both_rd_en",   32'(mem_rd_en), 1);
      check("both_wr_addr", 32'(mem_wr_addr), 32'((8 + k) % 16));
      check("both_rd_addr", 32'(mem_rd_addr), 32'(k % 16));
      check("both_cnt",     32'(empty_loc), 8);
      next_cycle();
    end
    WR_EN = 1'b0; RD_EN = 1'b0;
    #1;
    check("both_end_cnt", 32'(empty_loc), 8);
    check("both_end_wr",  32'(mem_wr_addr), 12);
    check("both_end_rd",  32'(mem_rd_addr), 4);
    next_cycle();
    write_n(8);
    WR_EN = 1'b1; RD_EN = 1'b1;
    #1;
    check("full_both_cnt",  32'(empty_loc), 0);
    check("full_both_wr",   32'(mem_wr_en), 0);
    check("full_both_rd",   32'(mem_rd_en), 1);
    check("full_both_addr", 32'(mem_rd_addr), 4);
    next_cycle();
    WR_EN = 1'b0; RD_EN = 1'b0;
    #1;
    check("full_both_after", 32'(empty_loc), 1);
    check("full_both_wptr",  32'(mem_wr_addr), 4);
    next_cycle();
    read_n(15);
    WR_EN = 1'b1; RD_EN = 1'b1;
    #1;
    check("empty_both_cnt",  32'(empty_loc), 16);
    check("empty_both_wr",   32'(mem_wr_en), 1);
    check("empty_both_rd",   32'(mem_rd_en), 0);
    check("empty_both_addr", 32'(mem_wr_addr), 4);
    next_cycle();
    WR_EN = 1'b0; RD_EN = 1'b0;
    #1;
    check("empty_both_after", 32'(empty_loc), 15);
    check("empty_both_rptr",  32'(mem_rd_addr), 4);
    next_cycle();

    // 5. CLR beats a write, flushes everything
    write_n(4);
    #1;
    check("pre_clr_cnt", 32'(empty_loc), 11);
    check("pre_clr_ovf", 32'(OVERFLOW), 1);
    check("pre_clr_udf", 32'(UNDERFLOW), 1);
    CLR = 1'b1; WR_EN = 1'b1;
    #1;
    check("clr_wr_en", 32'(mem_wr_en), 0);
    check("clr_rd_en", 32'(mem_rd_en), 0);
    next_cycle();
    CLR = 1'b0; WR_EN = 1'b0;
    #1;
    check("clr_cnt",     32'(empty_loc), 16);
    check("clr_wr_addr", 32'(mem_wr_addr), 0);
    check("clr_rd_addr", 32'(mem_rd_addr), 0);
    check("clr_ovf",     32'(OVERFLOW), 0);
    check("clr_udf",     32'(UNDERFLOW), 0);
    next_cycle();

    // 6. Asynchronous reset between edges
    write_n(3);
    #1;
    check("pre_rst_cnt", 32'(empty_loc), 13);
    #1;
    RST = 1'b0;
    WR_EN = 1'b1;
    #1;
    check("async_cnt",     32'(empty_loc), 16);
    check("async_wr_addr", 32'(mem_wr_addr), 0);
    check("async_wr_en",   32'(mem_wr_en), 0);
    next_cycle();
    next_cycle();
    RST = 1'b1;
    #1;
    check("post_rst_wr_en",   32'(mem_wr_en), 1);
    check("post_rst_wr_addr", 32'(mem_wr_addr), 0);
    next_cycle();
    WR_EN = 1'b0;
    #1;
    check("post_rst_cnt",  32'(empty_loc), 15);
    check("post_rst_wptr", 32'(mem_wr_addr), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
